// File: rtl/sb_rr_arbiter.sv
// Packet-aware round-robin arbiter: N switchboard streams share one registered output.
// The grant is held from the first beat of a packet until the beat carrying last=1.
module sb_rr_arbiter #(
  parameter int N  = 4,
  parameter int DW = 256,
  localparam int IDW = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N*DW-1:0]   in_data,
  input  logic [N*32-1:0]   in_dest,
  input  logic [N-1:0]      in_last,
  input  logic [N-1:0]      in_valid,
  output logic [N-1:0]      in_ready,
  output logic [DW-1:0]     out_data,
  output logic [31:0]       out_dest,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              locked,
  output logic [IDW-1:0]    grant_id
);

  localparam int PW = IDW + 1;

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t          state_reg, state_next;
  logic [IDW-1:0]  rr_ptr_reg, rr_ptr_next;
  logic [IDW-1:0]  sel;
  logic            sel_valid;
  logic            found;
  logic [PW-1:0]   pos;
  logic            can_accept;
  logic            xfer;

  logic [DW-1:0]   data_arr [N];
  logic [31:0]     dest_arr [N];

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
      assign data_arr[gi] = in_data[gi*DW +: DW];
      assign dest_arr[gi] = in_dest[gi*32 +: 32];
    end
  endgenerate

  assign locked = (state_reg == LOCKED);

  always_comb begin
    can_accept  = !out_valid || out_ready;
    sel         = grant_id;
    sel_valid   = 1'b0;
    found       = 1'b0;
    pos         = '0;
    in_ready    = '0;
    xfer        = 1'b0;
    state_next  = state_reg;
    rr_ptr_next = rr_ptr_reg;

    if (state_reg == LOCKED) begin
      // The owner keeps its ready even while its valid is low, so nobody else can cut in.
      sel       = grant_id;
      sel_valid = 1'b1;
    end else begin
      for (int k = 0; k < N; k++) begin
        pos = {1'b0, rr_ptr_reg} + PW'(k);
        if (pos >= PW'(N)) pos = pos - PW'(N);
        if (!found && in_valid[pos[IDW-1:0]]) begin
          found = 1'b1;
          sel   = pos[IDW-1:0];
        end
      end
      sel_valid = found;
    end

    if (sel_valid && !rst) in_ready[sel] = can_accept;
    xfer = in_ready[sel] && in_valid[sel];

    if (xfer) begin
      state_next = in_last[sel] ? IDLE : LOCKED;
      if (in_last[sel]) rr_ptr_next = (sel == IDW'(N-1)) ? '0 : sel + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= '0;
      grant_id   <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_dest   <= '0;
      out_last   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      rr_ptr_reg <= rr_ptr_next;
      if (xfer) begin
        out_data  <= data_arr[sel];
        out_dest  <= dest_arr[sel];
        out_last  <= in_last[sel];
        out_valid <= 1'b1;
        grant_id  <= sel;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sb_rr_arbiter.sv
// Randomized scoreboard bench for sb_rr_arbiter: per-source expected queues plus a
// packet-level round-robin reference model checked every cycle on the input side.
module tb_sb_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int IW = $clog2(N);

  typedef struct {
    logic [DW-1:0] data;
    logic [31:0]   dest;
    logic          last;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [N*DW-1:0]   in_data;
  logic [N*32-1:0]   in_dest;
  logic [N-1:0]      in_last;
  logic [N-1:0]      in_valid;
  logic [N-1:0]      in_ready;
  logic [DW-1:0]     out_data;
  logic [31:0]       out_dest;
  logic              out_last;
  logic              out_valid;
  logic              out_ready;
  logic              locked;
  logic [IW-1:0]     grant_id;

  sb_rr_arbiter #(.N(N), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_dest(in_dest), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_dest(out_dest), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .locked(locked), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  beat_t src_q [N][$];   // beats still to be offered by each source
  beat_t exp_q [N][$];   // beats each source must eventually see on the output
  int    seq [N];

  bit gen_en = 0;
  int gen_prob = 0, vprob = 0, rprob = 100, maxlen = 1;
  bit full_rate = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  task automatic gen_packet(int i);
    int len;
    beat_t b;
    len = $urandom_range(maxlen, 1);
    for (int k = 0; k < len; k++) begin
      b.data = {8'(i), 24'(seq[i]), 32'($urandom)};
      b.dest = $urandom;
      b.last = (k == len - 1);
      seq[i]++;
      src_q[i].push_back(b);
      exp_q[i].push_back(b);
    end
  endtask

  task automatic step();
    logic [N-1:0] acc;
    @(negedge clk);
    acc = in_valid & in_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      if (gen_en && src_q[i].size() == 0 && $urandom_range(99) < gen_prob) gen_packet(i);
      if (src_q[i].size() > 0 && $urandom_range(99) < vprob) begin
        in_valid[i]          = 1'b1;
        in_data[i*DW +: DW]  = src_q[i][0].data;
        in_dest[i*32 +: 32]  = src_q[i][0].dest;
        in_last[i]           = src_q[i][0].last;
      end else begin
        in_valid[i] = 1'b0;
      end
    end
    out_ready = ($urandom_range(99) < rprob);
  endtask

  task automatic drain();
    int k, pend;
    gen_en = 0; vprob = 100; rprob = 100;
    k = 0;
    do begin
      step();
      pend = 0;
      for (int i = 0; i < N; i++) pend += src_q[i].size();
      k++;
    end while ((pend != 0 || out_valid) && k < 400);
    chk("drain_timeout", 64'(pend != 0 || out_valid), 0);
    pend = 0;
    for (int i = 0; i < N; i++) pend += exp_q[i].size();
    chk("drain_no_loss", 64'(pend), 0);
  endtask

  // Monitor: reference arbitration model, output scoreboard, latency and hold checks.
  bit            m_open;
  int            m_owner, m_ptr, m_src, m_win, j;
  bit            m_found, out_open, prev_in_xfer, prev_hold, can_acc;
  int            out_src;
  beat_t         prev_in_beat, e;
  logic [DW-1:0] prev_out_data;
  logic [N-1:0]  exp_rdy;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst) begin
        m_open = 0; m_ptr = 0; m_owner = 0;
        out_open = 0; prev_in_xfer = 0; prev_hold = 0;
        continue;
      end

      if (prev_in_xfer) begin
        chk("latency_valid", 64'(out_valid), 1);
        chk("latency_data", out_data, prev_in_beat.data);
        chk("latency_dest", 64'(out_dest), 64'(prev_in_beat.dest));
        chk("latency_last", 64'(out_last), 64'(prev_in_beat.last));
      end else if (prev_hold) begin
        chk("hold_valid", 64'(out_valid), 1);
        chk("hold_data", out_data, prev_out_data);
      end
      if (full_rate) chk("no_bubble", 64'(out_valid), 1);

      if (out_valid && out_ready) begin
        m_src = int'(out_data[DW-1 -: 8]);
        chk("out_expected_beat", 64'(m_src < N && exp_q[m_src].size() > 0), 1);
        if (m_src < N && exp_q[m_src].size() > 0) begin
          e = exp_q[m_src].pop_front();
          chk("out_data", out_data, e.data);
          chk("out_dest", 64'(out_dest), 64'(e.dest));
          chk("out_last", 64'(out_last), 64'(e.last));
          chk("grant_id", 64'(grant_id), 64'(m_src));
          if (out_open) chk("no_interleave", 64'(m_src), 64'(out_src));
          out_open = !out_last;
          out_src  = m_src;
        end
      end

      can_acc = !out_valid || out_ready;
      exp_rdy = '0;
      if (m_open) begin
        m_win = m_owner;
        if (can_acc) exp_rdy[m_win[IW-1:0]] = 1'b1;
      end else begin
        m_found = 0; m_win = 0;
        for (int k = 0; k < N; k++) begin
          j = (m_ptr + k) % N;
          if (!m_found && in_valid[j[IW-1:0]]) begin
            m_found = 1; m_win = j;
          end
        end
        if (m_found && can_acc) exp_rdy[m_win[IW-1:0]] = 1'b1;
      end
      chk("locked", 64'(locked), 64'(m_open));
      chk("in_ready", 64'(in_ready), 64'(exp_rdy));

      prev_in_xfer = |(exp_rdy & in_valid);
      if (prev_in_xfer) begin
        prev_in_beat.data = in_data[m_win*DW +: DW];
        prev_in_beat.dest = in_dest[m_win*32 +: 32];
        prev_in_beat.last = in_last[m_win];
        if (prev_in_beat.last) begin
          m_open = 0;
          m_ptr  = (m_win + 1) % N;
        end else begin
          m_open  = 1;
          m_owner = m_win;
        end
      end
      prev_hold     = out_valid && !out_ready;
      prev_out_data = out_data;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int k;
    rst = 1'b1;
    in_valid = '0; in_data = '0; in_dest = '0; in_last = '0;
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) seq[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_dest", 64'(out_dest), 0);
    chk("rst_out_last", 64'(out_last), 0);
    chk("rst_locked", 64'(locked), 0);
    chk("rst_grant_id", 64'(grant_id), 0);
    chk("rst_in_ready", 64'(in_ready), 0);
    @(posedge clk);
    #2 rst = 1'b0;

    // All sources continuously sending single-beat packets: strict rotation, no bubbles.
    gen_en = 1; gen_prob = 100; maxlen = 1; vprob = 100; rprob = 100;
    repeat (3) step();
    full_rate = 1;
    repeat (40) step();
    full_rate = 0;
    drain();

    // Mixed packet lengths, owner stalls and backpressure.
    gen_en = 1; gen_prob = 40; maxlen = 5; vprob = 70; rprob = 60;
    repeat (600) step();
    drain();

    // Heavy backpressure.
    gen_en = 1; gen_prob = 60; maxlen = 4; vprob = 90; rprob = 20;
    repeat (300) step();
    drain();

    // Asynchronous reset while a packet is in progress.
    gen_en = 1; gen_prob = 100; maxlen = 6; vprob = 100; rprob = 100;
    k = 0;
    while (!locked && k < 60) begin
      step();
      k++;
    end
    chk("reach_locked", 64'(locked), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_locked", 64'(locked), 0);
    chk("arst_grant_id", 64'(grant_id), 0);
    chk("arst_in_ready", 64'(in_ready), 0);
    gen_en = 0;
    in_valid = '0;
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      exp_q[i].delete();
    end
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    maxlen = 2;
    gen_packet(3);
    k = 0;
    while (!out_valid && k < 10) begin
      step();
      k++;
    end
    #1;
    chk("post_reset_out_valid", 64'(out_valid), 1);
    chk("post_reset_grant", 64'(grant_id), 3);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
